decim_ctrl: RTL

Sequencing controller for the 16-bit sigma-delta decimator. It owns the decimation window: it selects the ratio, frames each window with enable, last and clear strobes, and captures the decimator result at every window boundary. It discards the settling words after each start and hands finished words downstream through a 2-entry valid/ready buffer. It sits between the run-control registers and the decimator datapath.

---
 rtl/decim_pkg.sv | 25 ++
 rtl/decim_obuf.sv | 77 +++++++
 rtl/decim_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/decim_pkg.sv
// Shared types and window-length helpers for the sigma-delta decimation controller.
package decim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam int L_MODE0 = 256;
  localparam int L_MODE1 = 1024;

  function automatic logic [10:0] window_len(input logic mode);
    return mode ? 11'(L_MODE1) : 11'(L_MODE0);
  endfunction

  // Index of the final bit in a window; L-1 always fits the 10-bit counter.
  function automatic logic [9:0] last_bit(input logic mode);
    logic [10:0] len;
    len = window_len(mode);
    return 10'(len - 11'd1);
  endfunction

endpackage

// File: rtl/decim_obuf.sv
// Two-entry valid/ready output buffer; the head word is presented on dout.
module decim_obuf #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        dvalid,
  output logic        full
);

  logic [1:0]  count_q, count_d;
  logic [15:0] head_q, head_d;
  logic [15:0] tail_q, tail_d;
  logic        dvalid_q, dvalid_d;
  logic        push_ok;

  assign full    = (count_q == 2'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign dout    = head_q;
  assign dvalid  = dvalid_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_ok, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = din;
        end else begin
          tail_d = din;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Popping the last word leaves the stale head in place; only dvalid drops.
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din;
        end else begin
          head_d = din;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
    dvalid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= 16'd0;
      tail_q   <= 16'd0;
      dvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      dvalid_q <= dvalid_d;
    end
  end

endmodule

// File: rtl/decim_ctrl.sv
// Decimation window sequencer: frames windows with EN/CLR/LAST strobes, discards
// settling words after START and queues finished words into the output buffer.
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int SETTLE_WORDS = 2,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic        MODE_REQ,
  output logic        DEC_MODE,
  output logic        DEC_EN,
  output logic        DEC_CLR,
  output logic        DEC_LAST,
  input  logic [15:0] Q_IN,
  output logic [15:0] DOUT,
  output logic        DVALID,
  input  logic        DREADY,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [15:0] WORD_CNT
);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  settle_q, settle_d;
  logic        mode_q, mode_d;
  logic        ovr_q, ovr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        en_q, en_d;
  logic        clr_q, clr_d;
  logic        last_q, last_d;
  logic        cap_q, cap_d;
  logic        capture, push, pop, full, active_d;
  logic [9:0]  cnt_wrap;

  assign capture  = cap_q && ((state_q == SETTLE) || (state_q == RUN));
  assign pop      = DVALID && DREADY;
  assign cnt_wrap = (cnt_q == last_bit(mode_q)) ? 10'd0 : (cnt_q + 10'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    ovr_d    = ovr_q;
    wcnt_d   = wcnt_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 10'd0;
        if (START) begin
          mode_d   = MODE_REQ;
          ovr_d    = 1'b0;
          wcnt_d   = 16'd0;
          settle_d = 4'(SETTLE_WORDS);
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = 10'd1;
        state_d = (settle_q != 4'd0) ? SETTLE : RUN;
      end
      SETTLE: begin
        cnt_d = cnt_wrap;
        if (capture) begin
          settle_d = settle_q - 4'd1;
          if (settle_q <= 4'd1) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_wrap;
        if (capture) begin
          if (!full || pop) begin
            push   = 1'b1;
            wcnt_d = wcnt_q + 16'd1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort drops the partial window but leaves any capture of this cycle processed.
    if (STOP && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 10'd0;
    end
    active_d = (state_d != IDLE);
    en_d     = active_d;
    clr_d    = active_d && (cnt_d == 10'd0);
    last_d   = active_d && (cnt_d == last_bit(mode_d));
    cap_d    = last_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 10'd0;
      settle_q <= 4'd0;
      mode_q   <= 1'b0;
      ovr_q    <= 1'b0;
      wcnt_q   <= 16'd0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      last_q   <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      ovr_q    <= ovr_d;
      wcnt_q   <= wcnt_d;
      en_q     <= en_d;
      clr_q    <= clr_d;
      last_q   <= last_d;
      cap_q    <= cap_d;
    end
  end

  decim_obuf #(
    .DEPTH (FIFO_DEPTH)
  ) u_obuf (
    .clk    (CLK),
    .rst    (RST),
    .push   (push),
    .pop    (pop),
    .din    (Q_IN),
    .dout   (DOUT),
    .dvalid (DVALID),
    .full   (full)
  );

  assign DEC_MODE = mode_q;
  assign DEC_EN   = en_q;
  assign DEC_CLR  = clr_q;
  assign DEC_LAST = last_q;
  assign BUSY     = (state_q != IDLE);
  assign OVERRUN  = ovr_q;
  assign WORD_CNT = wcnt_q;

endmodule
